// File: rtl/instr_reg_sched_if.sv
// Bundle of producer, consumer and register-side signals around the instruction
// register scheduler; the scheduler takes the slave side.
interface instr_reg_sched_if #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 32,
  parameter int ADDR_W    = 5
);
  logic [1:0]           wr_req;
  logic [1:0]           wr_gnt;
  logic [OPCODE_W-1:0]  opcode0;
  logic [OPCODE_W-1:0]  opcode1;
  logic [OPERAND_W-1:0] op_a0;
  logic [OPERAND_W-1:0] op_a1;
  logic [OPERAND_W-1:0] op_b0;
  logic [OPERAND_W-1:0] op_b1;
  logic                 rd_req;
  logic                 rd_gnt;
  logic                 rd_valid;
  logic                 clear;
  logic                 busy;
  logic                 full;
  logic                 empty;
  logic [ADDR_W:0]      count;
  logic                 load_en;
  logic [ADDR_W-1:0]    write_pointer;
  logic [ADDR_W-1:0]    read_pointer;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand_a;
  logic [OPERAND_W-1:0] operand_b;

  modport master (
    output wr_req, opcode0, opcode1, op_a0, op_a1, op_b0, op_b1, rd_req, clear,
    input  wr_gnt, rd_gnt, rd_valid, busy, full, empty, count, load_en,
           write_pointer, read_pointer, opcode, operand_a, operand_b
  );

  modport slave (
    input  wr_req, opcode0, opcode1, op_a0, op_a1, op_b0, op_b1, rd_req, clear,
    output wr_gnt, rd_gnt, rd_valid, busy, full, empty, count, load_en,
           write_pointer, read_pointer, opcode, operand_a, operand_b
  );
endinterface

// File: rtl/instr_reg_sched.sv
// Instruction register scheduler: round-robin write arbitration of two producers,
// circular-queue pointer/count tracking, in-order reads and a full-array clear.
module instr_reg_sched #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 32,
  parameter int ADDR_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  instr_reg_sched_if.slave   bus
);
  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ZERO_C   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t               state_r, state_next_s;
  logic [ADDR_W-1:0]    wr_ptr_r, rd_ptr_r, write_pointer_r, read_pointer_r;
  logic [ADDR_W:0]      count_r;
  logic                 last_r;
  logic                 load_en_r, rd_valid_r;
  logic [OPCODE_W-1:0]  opcode_r;
  logic [OPERAND_W-1:0] operand_a_r, operand_b_r;
  logic                 full_s, empty_s, idle_s, wr_en_s, rd_en_s, win_s;
  logic [1:0]           wr_gnt_s;

  // Winning producer index; on a tie the one not granted last time wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    logic w;
    case (req)
      2'b01:   w = 1'b0;
      2'b10:   w = 1'b1;
      2'b11:   w = ~last;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // Grant decisions from the pre-update occupancy; a clear request blocks both grants.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    empty_s = (count_r == ZERO_C);
    idle_s  = (state_r == IDLE) && !bus.clear;
    wr_en_s = idle_s && !full_s && (bus.wr_req != 2'b00);
    rd_en_s = idle_s && !empty_s && bus.rd_req;
    win_s   = pick_winner(bus.wr_req, last_r);
    if (wr_en_s) begin
      wr_gnt_s = win_s ? 2'b10 : 2'b01;
    end else begin
      wr_gnt_s = 2'b00;
    end
  end

  // Next-state logic; the clear walk ends once the last index has been driven.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.clear) state_next_s = CLEAR;
        else           state_next_s = IDLE;
      end
      CLEAR: begin
        if (write_pointer_r == LAST_IDX) state_next_s = IDLE;
        else                             state_next_s = CLEAR;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Pointers, occupancy and registered register-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r        <= {ADDR_W{1'b0}};
      rd_ptr_r        <= {ADDR_W{1'b0}};
      count_r         <= ZERO_C;
      last_r          <= 1'b1;
      load_en_r       <= 1'b0;
      rd_valid_r      <= 1'b0;
      write_pointer_r <= {ADDR_W{1'b0}};
      read_pointer_r  <= {ADDR_W{1'b0}};
      opcode_r        <= {OPCODE_W{1'b0}};
      operand_a_r     <= {OPERAND_W{1'b0}};
      operand_b_r     <= {OPERAND_W{1'b0}};
    end else begin
      case (state_r)
        CLEAR: begin
          rd_valid_r <= 1'b0;
          if (write_pointer_r == LAST_IDX) begin
            load_en_r <= 1'b0;
            wr_ptr_r  <= {ADDR_W{1'b0}};
            rd_ptr_r  <= {ADDR_W{1'b0}};
            count_r   <= ZERO_C;
          end else begin
            load_en_r       <= 1'b1;
            write_pointer_r <= write_pointer_r + PTR_ONE;
          end
        end
        IDLE: begin
          if (bus.clear) begin
            // First clear strobe is staged here so it lines up with the first CLEAR cycle.
            load_en_r       <= 1'b1;
            write_pointer_r <= {ADDR_W{1'b0}};
            opcode_r        <= {OPCODE_W{1'b0}};
            operand_a_r     <= {OPERAND_W{1'b0}};
            operand_b_r     <= {OPERAND_W{1'b0}};
            rd_valid_r      <= 1'b0;
          end else begin
            if (wr_en_s) begin
              load_en_r       <= 1'b1;
              write_pointer_r <= wr_ptr_r;
              opcode_r        <= win_s ? bus.opcode1 : bus.opcode0;
              operand_a_r     <= win_s ? bus.op_a1 : bus.op_a0;
              operand_b_r     <= win_s ? bus.op_b1 : bus.op_b0;
              wr_ptr_r        <= wr_ptr_r + PTR_ONE;
              last_r          <= win_s;
            end else begin
              load_en_r <= 1'b0;
            end
            if (rd_en_s) begin
              rd_valid_r     <= 1'b1;
              read_pointer_r <= rd_ptr_r;
              rd_ptr_r       <= rd_ptr_r + PTR_ONE;
            end else begin
              rd_valid_r <= 1'b0;
            end
            case ({wr_en_s, rd_en_s})
              2'b10:   count_r <= count_r + ONE_C;
              2'b01:   count_r <= count_r - ONE_C;
              default: count_r <= count_r;
            endcase
          end
        end
        default: begin
          load_en_r  <= 1'b0;
          rd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_gnt        = wr_gnt_s;
  assign bus.rd_gnt        = rd_en_s;
  assign bus.rd_valid      = rd_valid_r;
  assign bus.busy          = (state_r == CLEAR);
  assign bus.full          = full_s;
  assign bus.empty         = empty_s;
  assign bus.count         = count_r;
  assign bus.load_en       = load_en_r;
  assign bus.write_pointer = write_pointer_r;
  assign bus.read_pointer  = read_pointer_r;
  assign bus.opcode        = opcode_r;
  assign bus.operand_a     = operand_a_r;
  assign bus.operand_b     = operand_b_r;
endmodule

// File: tb/tb_instr_reg_sched.sv
// Self-checking bench for instr_reg_sched: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_instr_reg_sched;
  localparam int OW = 4, DW = 32, AW = 5, DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_reg_sched_if #(.OPCODE_W(OW), .OPERAND_W(DW), .ADDR_W(AW)) bus();
  instr_reg_sched #(.OPCODE_W(OW), .OPERAND_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: the queue holds the slot index of every stored instruction.
  int m_q[$];
  int m_wptr, m_last, m_k;
  bit m_clear;
  logic          e_load, e_rv;
  int            e_wp, e_rp;
  logic [OW-1:0] e_opc;
  logic [DW-1:0] e_a, e_b;
  logic [1:0]    a_gnt;
  logic          a_rgnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wptr = 0; m_last = 1; m_k = 0; m_clear = 1'b0;
    e_load = 1'b0; e_rv = 1'b0; e_wp = 0; e_rp = 0;
    e_opc = '0; e_a = '0; e_b = '0;
  endtask

  task automatic check_outputs();
    chk("load_en", 64'(bus.load_en), 64'(e_load));
    chk("write_pointer", 64'(bus.write_pointer), 64'(e_wp));
    chk("opcode", 64'(bus.opcode), 64'(e_opc));
    chk("operand_a", 64'(bus.operand_a), 64'(e_a));
    chk("operand_b", 64'(bus.operand_b), 64'(e_b));
    chk("rd_valid", 64'(bus.rd_valid), 64'(e_rv));
    chk("read_pointer", 64'(bus.read_pointer), 64'(e_rp));
    chk("count", 64'(bus.count), 64'(m_q.size()));
    chk("full", 64'(bus.full), 64'(m_q.size() == DEPTH));
    chk("empty", 64'(bus.empty), 64'(m_q.size() == 0));
    chk("busy", 64'(bus.busy), 64'(m_clear));
  endtask

  // One clock cycle: starts and ends 1 time unit after a rising edge.
  task automatic step(input logic [1:0] wreq, input logic rreq, input logic clr);
    logic [1:0] eg;
    logic       erg;
    int         win;
    bus.wr_req = wreq; bus.rd_req = rreq; bus.clear = clr;
    bus.opcode0 = OW'($urandom); bus.opcode1 = OW'($urandom);
    bus.op_a0 = $urandom; bus.op_a1 = $urandom;
    bus.op_b0 = $urandom; bus.op_b1 = $urandom;
    eg = 2'b00; erg = 1'b0; win = 0;
    if (!m_clear && !clr) begin
      if (wreq != 2'b00 && m_q.size() < DEPTH) begin
        if (wreq == 2'b11) win = (m_last == 0) ? 1 : 0;
        else               win = (wreq == 2'b10) ? 1 : 0;
        eg = (win == 1) ? 2'b10 : 2'b01;
      end
      if (rreq && m_q.size() > 0) erg = 1'b1;
    end
    #3;
    a_gnt = bus.wr_gnt; a_rgnt = bus.rd_gnt;
    chk("wr_gnt", 64'(a_gnt), 64'(eg));
    chk("rd_gnt", 64'(a_rgnt), 64'(erg));
    if (m_clear) begin
      e_rv = 1'b0;
      if (m_k == DEPTH - 1) begin
        m_clear = 1'b0; e_load = 1'b0; m_q.delete(); m_wptr = 0;
      end else begin
        m_k++; e_load = 1'b1; e_wp = m_k;
      end
    end else if (clr) begin
      m_clear = 1'b1; m_k = 0; e_load = 1'b1; e_wp = 0;
      e_opc = '0; e_a = '0; e_b = '0; e_rv = 1'b0;
    end else begin
      if (erg) begin e_rv = 1'b1; e_rp = m_q.pop_front(); end
      else e_rv = 1'b0;
      if (eg != 2'b00) begin
        e_load = 1'b1; e_wp = m_wptr;
        e_opc = (win == 1) ? bus.opcode1 : bus.opcode0;
        e_a   = (win == 1) ? bus.op_a1 : bus.op_a0;
        e_b   = (win == 1) ? bus.op_b1 : bus.op_b0;
        m_q.push_back(m_wptr);
        m_wptr = (m_wptr + 1) % DEPTH;
        m_last = win;
      end else e_load = 1'b0;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    bus.wr_req = 2'b00; bus.rd_req = 1'b0; bus.clear = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0] wreq; logic rreq;
    logic [1:0] gnt;  logic rgnt;
    logic load; int wp; logic rv; int rp; int cnt;
  } vec_t;
  vec_t tbl[11];

  initial begin
    reset = 1'b1;
    bus.wr_req = 2'b00; bus.rd_req = 1'b0; bus.clear = 1'b0;
    bus.opcode0 = '0; bus.opcode1 = '0;
    bus.op_a0 = '0; bus.op_a1 = '0; bus.op_b0 = '0; bus.op_b1 = '0;
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check_outputs();

    // Fairness, in-order reads, simultaneous grants, read blocked while empty.
    tbl[0]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 0, 1'b0, 0, 1};
    tbl[1]  = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b1, 1, 1'b0, 0, 2};
    tbl[2]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 2, 1'b0, 0, 3};
    tbl[3]  = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b1, 3, 1'b0, 0, 4};
    tbl[4]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3, 1'b1, 0, 3};
    tbl[5]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3, 1'b1, 1, 2};
    tbl[6]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3, 1'b1, 2, 1};
    tbl[7]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 4, 1'b1, 3, 1};
    tbl[8]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 4, 1'b1, 4, 0};
    tbl[9]  = '{2'b10, 1'b1, 2'b10, 1'b0, 1'b1, 5, 1'b0, 4, 1};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 5, 1'b0, 4, 1};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wreq, tbl[i].rreq, 1'b0);
      chk("tbl_wr_gnt", 64'(a_gnt), 64'(tbl[i].gnt));
      chk("tbl_rd_gnt", 64'(a_rgnt), 64'(tbl[i].rgnt));
      chk("tbl_load_en", 64'(bus.load_en), 64'(tbl[i].load));
      chk("tbl_write_pointer", 64'(bus.write_pointer), 64'(tbl[i].wp));
      chk("tbl_rd_valid", 64'(bus.rd_valid), 64'(tbl[i].rv));
      chk("tbl_read_pointer", 64'(bus.read_pointer), 64'(tbl[i].rp));
      chk("tbl_count", 64'(bus.count), 64'(tbl[i].cnt));
    end

    // Fill to full, write blocked while full even with a same-cycle read, then wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(2'($urandom_range(3, 1)), 1'b0, 1'b0);
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_count", 64'(bus.count), 64'd32);
    step(2'b11, 1'b0, 1'b0);
    chk("full_no_gnt", 64'(a_gnt), 64'd0);
    step(2'b01, 1'b1, 1'b0);
    chk("full_wr_blocked", 64'(a_gnt), 64'd0);
    chk("full_rd_gnt", 64'(a_rgnt), 64'd1);
    chk("full_count_after_rd", 64'(bus.count), 64'd31);
    step(2'b01, 1'b0, 1'b0);
    chk("wrap_gnt", 64'(a_gnt), 64'd1);
    chk("wrap_pointer", 64'(bus.write_pointer), 64'd0);

    // Clear sequence with requests held active throughout.
    do_reset();
    for (int i = 0; i < 5; i++) step(2'b01, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    chk("clear_blocks_gnt", 64'(a_gnt), 64'd0);
    chk("clear_first_ptr", 64'(bus.write_pointer), 64'd0);
    for (int k = 1; k < DEPTH; k++) begin
      step(2'b11, 1'b1, 1'($urandom_range(1, 0)));
      chk("clear_ptr", 64'(bus.write_pointer), 64'(k));
      chk("clear_busy", 64'(bus.busy), 64'd1);
    end
    step(2'b00, 1'b0, 1'b0);
    chk("clear_done_busy", 64'(bus.busy), 64'd0);
    chk("clear_done_count", 64'(bus.count), 64'd0);
    step(2'b01, 1'b0, 1'b0);
    chk("clear_resume_gnt", 64'(a_gnt), 64'd1);
    chk("clear_resume_ptr", 64'(bus.write_pointer), 64'd0);

    // Reset in the middle of a clear.
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(2'b00, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic with write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int wp_pct;
      logic [1:0] wr;
      wp_pct = ((i / 300) % 2 == 0) ? 85 : 30;
      wr = ($urandom_range(99, 0) < wp_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
      if ($urandom_range(999, 0) == 0) do_reset();
      else step(wr, 1'($urandom_range(1, 0)), ($urandom_range(149, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
